// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the logic unit pipeline: op codes, payload layout and
// the output-stage state encoding.
package logic_unit_pipe_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

  // Number of flag bits carried alongside the result: {par, ones, zero}.
  localparam int FLAG_W = 3;

  // Encoding is {OUT.full, SKID.full}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b10,
    ST_FULL  = 2'b11
  } buf_state_e;

endpackage

// File: rtl/logic_unit_pipe_skid_buffer.sv
// Two-entry output stage: an output register plus one skid register, with a
// registered in_ready so the upstream path is cut at this boundary.
module skid_buffer
  import logic_unit_pipe_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output buf_state_e   state
);

  buf_state_e   state_q, state_d;
  logic         in_ready_q;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         drain;
  logic         load_out;
  logic         load_skid;
  logic         skid_to_out;

  assign accept = in_valid & in_ready_q;
  assign drain  = (state_q != ST_EMPTY) & out_ready;

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d  = ST_BUSY;
          load_out = 1'b1;
        end
      end
      ST_BUSY: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (drain) begin
          state_d     = ST_BUSY;
          skid_to_out = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      if (load_out) begin
        out_q <= in_data;
      end else if (skid_to_out) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_q;
  assign state     = state_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// WIDTH-bit, 8-operation bitwise logic unit with a registered, skid-buffered
// output stage, registered reduction flags and a completed-transaction counter.
//
// Handshake: a beat transfers on a rising edge where valid & ready are both 1.
// valid never waits on ready; once out_valid is high, out_y and the flags hold
// until the transfer; in_ready depends only on registered state.
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic               out_zero,
  output logic               out_ones,
  output logic               out_par,
  output logic [COUNT_W-1:0] txn_count,
  output buf_state_e         dbg_state
);

  localparam int PW = WIDTH + FLAG_W;

  logic [WIDTH-1:0]   y;
  logic [PW-1:0]      in_payload;
  logic [PW-1:0]      out_payload;
  logic [COUNT_W-1:0] txn_q;

  always_comb begin
    y = '0;
    case (in_op)
      OP_AND:  y = in_a & in_b;
      OP_OR:   y = in_a | in_b;
      OP_XOR:  y = in_a ^ in_b;
      OP_NAND: y = ~(in_a & in_b);
      OP_NOR:  y = ~(in_a | in_b);
      OP_XNOR: y = ~(in_a ^ in_b);
      OP_NOT:  y = ~in_a;
      OP_PASS: y = in_a;
      default: y = '0;
    endcase
  end

  // Flags are computed before the register so they travel with their result.
  assign in_payload = {^y, &y, ~|y, y};

  skid_buffer #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload),
    .state     (dbg_state)
  );

  assign out_y    = out_payload[WIDTH-1:0];
  assign out_zero = out_payload[WIDTH];
  assign out_ones = out_payload[WIDTH+1];
  assign out_par  = out_payload[WIDTH+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_q <= '0;
    end else if (out_valid && out_ready) begin
      txn_q <= txn_q + COUNT_W'(1);
    end
  end

  assign txn_count = txn_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: a truth-table reference model feeds an
// expected queue that a negedge monitor drains against the DUT output.
module tb_logic_unit_pipe;
  import logic_unit_pipe_pkg::*;

  localparam int W  = 8;
  localparam int PW = W + 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [2:0]    in_op = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;

  logic          in_ready0, out_valid0, zero0, ones0, par0;
  logic [W-1:0]  y0;
  logic [15:0]   txn0;
  buf_state_e    st0;

  logic          in_ready1, out_valid1, zero1, ones1, par1;
  logic [W-1:0]  y1;
  logic [1:0]    txn1;
  buf_state_e    st1;

  logic_unit_pipe #(.WIDTH(W), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid0),
    .out_ready(out_ready), .out_y(y0), .out_zero(zero0), .out_ones(ones0),
    .out_par(par0), .txn_count(txn0), .dbg_state(st0)
  );

  logic_unit_pipe #(.WIDTH(W), .COUNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid1),
    .out_ready(out_ready), .out_y(y1), .out_zero(zero1), .out_ones(ones1),
    .out_par(par1), .txn_count(txn1), .dbg_state(st1)
  );

  // scoreboard state
  logic [PW-1:0] exp_q[$];
  int            acc_q[$];
  bit            strict_q[$];
  int            hs_cnt = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: per-bit truth table indexed by {a_bit, b_bit}
  function automatic logic [2:0] flags_of(input logic [W-1:0] y);
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++) ones += int'(y[i]);
    return {(ones % 2) == 1, ones == W, ones == 0};
  endfunction

  function automatic logic [PW-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [3:0]   tt;
    logic [W-1:0] y;
    case (op)
      OP_AND:  tt = 4'b1000;
      OP_OR:   tt = 4'b1110;
      OP_XOR:  tt = 4'b0110;
      OP_NAND: tt = 4'b0111;
      OP_NOR:  tt = 4'b0001;
      OP_XNOR: tt = 4'b1001;
      OP_NOT:  tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < W; i++) y[i] = tt[{a[i], b[i]}];
    return {flags_of(y), y};
  endfunction

  // monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      strict_q.delete();
      hs_cnt = 0;
    end else begin
      chk("txn_count", 32'(txn0), hs_cnt & 32'hFFFF);
      chk("txn_count_w2", 32'(txn1), hs_cnt % 4);
      if (out_valid0) begin
        chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          chk("result", 32'({par0, ones0, zero0, y0}), 32'(exp_q[0]));
          if (strict_q[0]) chk("latency", cyc, acc_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            void'(strict_q.pop_front());
            hs_cnt++;
          end
        end
      end
    end
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit strict, input logic [PW-1:0] exp);
    bit done;
    done = 0;
    in_op = op;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      if (in_ready0) begin
        exp_q.push_back(exp);
        acc_q.push_back(cyc + 1);
        strict_q.push_back(strict);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic send_m(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit strict);
    send(op, a, b, strict, model(op, a, b));
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_out_payload", 32'({par0, ones0, zero0, y0}), 32'd0);
    chk("rst_txn", 32'(txn0), 32'd0);
    chk("rst_in_ready", 32'(in_ready0), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_in_ready", 32'(in_ready0), 32'd1);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200 && exp_q.size() > 0; t++) idle(1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  logic [W-1:0] t2_y[8] = '{8'h42, 8'hDB, 8'h99, 8'hBD, 8'h24, 8'h66, 8'h3C, 8'hC3};
  bit           rnd_done = 0;

  initial begin
    // reset held from time 0 for 3 clocks
    repeat (3) @(posedge clk);
    #1;
    chk("init_out_valid", 32'(out_valid0), 32'd0);
    chk("init_txn", 32'(txn0), 32'd0);
    chk("init_in_ready", 32'(in_ready0), 32'd0);
    chk("init_payload", 32'({par0, ones0, zero0, y0}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("init_release_in_ready", 32'(in_ready0), 32'd1);

    // all ops on the reference operands, back to back
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      send(3'(i), 8'hC3, 8'h5A, 1, {flags_of(t2_y[i]), t2_y[i]});

    // flag corner cases: {par, ones, zero, y}
    send(OP_XOR, 8'hA5, 8'hA5, 1, {3'b001, 8'h00});
    send(OP_OR, 8'hF0, 8'h0F, 1, {3'b010, 8'hFF});
    send(OP_PASS, 8'h01, 8'h00, 1, {3'b100, 8'h01});
    wait_drain();

    // backpressure: two beats fill OUT and SKID, then release
    out_ready = 1'b0;
    send_m(OP_XOR, 8'h12, 8'h34, 0);
    send_m(OP_NAND, 8'h56, 8'h78, 0);
    chk("bp_in_ready_low", 32'(in_ready0), 32'd0);
    idle(1);
    out_ready = 1'b1;
    send_m(OP_NOR, 8'h9A, 8'hBC, 0);
    send_m(OP_NOT, 8'hDE, 8'hF0, 0);
    wait_drain();

    // randomized traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send_m(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0);
          idle($urandom_range(0, 2));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // reset while FULL: nothing stale may appear afterwards
    out_ready = 1'b0;
    send_m(OP_AND, 8'hFF, 8'h0F, 0);
    send_m(OP_OR, 8'h10, 8'h01, 0);
    do_reset();
    out_ready = 1'b1;
    idle(6);

    // counter wrap on the 2-bit instance
    for (int i = 0; i < 5; i++) send_m(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1);
    idle(3);
    chk("wrap_txn_w2", 32'(txn1), 32'd1);
    chk("wrap_txn", 32'(txn0), 32'd5);

    // full throughput from a fresh reset
    do_reset();
    for (int i = 0; i < 20; i++) send_m(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1);
    idle(3);
    chk("tput_txn", 32'(txn0), 32'd20);
    chk("tput_txn_w2", 32'(txn1), 32'd0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
